// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller: op encodings,
// enable levels, FSM state codes and the access fault check.
package data_mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 17;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // op[3] selects store
    localparam int OP_STORE_BIT = 3;

    // RAM enable active levels
    localparam logic ChipEnable  = 1'b1;
    localparam logic WriteEnable = 1'b1;
    localparam logic ReadEnable  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // True when the access must be rejected: unknown funct3, unsigned
    // store, or a halfword/word access that is not naturally aligned.
    function automatic logic op_fault(input logic [3:0] op, input logic [1:0] a);
        logic illegal;
        logic misalign;
        illegal  = (op[2:0] == 3'b011) || (op[2:0] == 3'b110) || (op[2:0] == 3'b111) ||
                   (op[OP_STORE_BIT] && op[2]);
        misalign = ((op[1:0] == 2'b01) && a[0]) ||
                   ((op[1:0] == 2'b10) && (a != 2'b00));
        return illegal || misalign;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_mem_lane_align.sv
// Byte/halfword lane handling: extracts and extends load data from a RAM
// word, and merges narrow store data into a previously read word.
module mem_lane_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane and sign/zero extend it for loads
    always_comb begin
        byte_sel  = word[{byte_off, 3'b000} +: 8];
        half_sel  = byte_off[1] ? word[31:16] : word[15:0];
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_data = word;
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = '0;
        endcase
    end

    // Overlay the store lane onto the read word; full-word stores ignore it
    always_comb begin
        store_word = word;
        case (funct3[1:0])
            2'b00: store_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (byte_off[1]) store_word[31:16] = wdata[15:0];
                else             store_word[15:0]  = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data RAM controller: one request at a time, read-modify-write
// for sub-word stores, single-cycle fault reporting for bad accesses.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [3:0]        op_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              done_o,
    output logic              err_o,
    output logic              stall_o,
    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic              ram_re_o,
    output logic [ADDR_W-1:0] ram_waddr_o,
    output logic [ADDR_W-1:0] ram_raddr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i
);

    state_t              state_q, state_d;
    logic [3:0]          op_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         word_q;
    logic [31:0]         load_data;
    logic [31:0]         store_word;
    logic                accept;

    // Address bits above the RAM range wrap and are intentionally dropped
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_i[31:ADDR_W+2];

    assign accept = (state_q == ST_IDLE) && req_i;

    mem_lane_align u_align (
        .funct3     (op_q[2:0]),
        .byte_off   (addr_q[1:0]),
        .word       (word_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // State register, request latch and read-data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= op_i;
                addr_q  <= addr_i[ADDR_W+1:0];
                wdata_q <= wdata_i;
            end
            if (state_q == ST_RD) word_q <= ram_rdata_i;
        end
    end

    // Next state and all outputs; stall is masked by rst so reset forces zeros
    always_comb begin
        state_d     = state_q;
        done_o      = 1'b0;
        err_o       = 1'b0;
        stall_o     = 1'b0;
        ram_ce_o    = ~ChipEnable;
        ram_we_o    = ~WriteEnable;
        ram_re_o    = ~ReadEnable;
        rdata_o     = '0;
        ram_raddr_o = '0;
        ram_waddr_o = '0;
        ram_wdata_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_i && !rst) begin
                    stall_o = 1'b1;
                    if (op_fault(op_i, addr_i[1:0]))
                        state_d = ST_ERR;
                    else if (op_i[OP_STORE_BIT] && (op_i[2:0] == F3_W))
                        state_d = ST_WR;
                    else
                        state_d = ST_RD;
                end
            end
            ST_RD: begin
                stall_o     = 1'b1;
                ram_ce_o    = ChipEnable;
                ram_re_o    = ReadEnable;
                ram_raddr_o = addr_q[ADDR_W+1:2];
                state_d     = op_q[OP_STORE_BIT] ? ST_WR : ST_DONE;
            end
            ST_WR: begin
                stall_o     = 1'b1;
                ram_ce_o    = ChipEnable;
                ram_we_o    = WriteEnable;
                ram_waddr_o = addr_q[ADDR_W+1:2];
                ram_wdata_o = store_word;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                done_o  = 1'b1;
                rdata_o = op_q[OP_STORE_BIT] ? 32'd0 : load_data;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                done_o  = 1'b1;
                err_o   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl with a behavioural RAM and a
// scoreboard of expected completions.
module tb_data_mem_ctrl;

    localparam int AW = 8;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic [3:0]    op;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          done, err, stall;
    logic          ram_ce, ram_we, ram_re;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [31:0]   ram_wdata, ram_rdata;

    logic [31:0]   mem [0:(1<<AW)-1];

    typedef struct { logic [31:0] rdata; logic err; } exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .req_i(req), .op_i(op), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata), .done_o(done), .err_o(err), .stall_o(stall),
        .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_re_o(ram_re),
        .ram_waddr_o(ram_waddr), .ram_raddr_o(ram_raddr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    assign ram_rdata = mem[ram_raddr];
    always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;

    // Reference load extraction, written shift-and-mask style
    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [1:0] off);
        logic [31:0] s;
        s = w >> (8 * off);
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b010:  return w;
            3'b100:  return s & 32'h0000_00FF;
            3'b101:  return s & 32'h0000_FFFF;
            default: return 32'd0;
        endcase
    endfunction

    // Completion monitor: pops the scoreboard on every done cycle
    always @(negedge clk) begin
        if (ram_re && ram_we) begin
            n_vec++;
            n_bad++;
            $display("FAIL re_we_overlap: re=%b we=%b, required not both 1", ram_re, ram_we);
        end
        if (done) begin
            exp_t e;
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: rdata=%h err=%b with empty scoreboard", rdata, err);
            end else begin
                e = sb.pop_front();
                if (rdata !== e.rdata || err !== e.err) begin
                    n_bad++;
                    $display("FAIL completion: rdata=%h err=%b, required rdata=%h err=%b",
                             rdata, err, e.rdata, e.err);
                end
            end
        end
    end

    // Drive one request from an IDLE negedge; report latency and RAM activity
    task automatic run_req(input logic [3:0] o, input logic [31:0] a, input logic [31:0] w,
                           input bit keep, output int lat, output int re_n, output int we_n,
                           output logic [AW-1:0] ra);
        req = 1'b1; op = o; addr = a; wdata = w;
        lat = 0; re_n = 0; we_n = 0; ra = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ram_re) begin re_n++; ra = ram_raddr; end
            if (ram_we) we_n++;
            if (done) begin lat = c; break; end
        end
        if (!keep) begin
            req = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b1; op = OP_LW; addr = 32'h10; wdata = 32'hFFFF_FFFF;
        #1;
        n_vec++;
        if ({rdata, done, err, stall, ram_ce, ram_we, ram_re, ram_waddr, ram_raddr, ram_wdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: stall=%b ce=%b rdata=%h, required all zero", stall, ram_ce, rdata);
        end
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if (stall !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_no_req: stall=%b done=%b, required 0 0", stall, done);
        end
        @(negedge clk);
    endtask

    task automatic test_load_word();
        int lat, re_n, we_n; logic [AW-1:0] ra;
        sb.push_back('{32'h8899_AABB, 1'b0});
        run_req(OP_LW, 32'h0000_0010, 32'd0, 1'b0, lat, re_n, we_n, ra);
        n_vec++;
        if (lat !== 2 || re_n !== 1 || we_n !== 0 || ra !== 8'd4) begin
            n_bad++;
            $display("FAIL lw_timing: lat=%0d re=%0d we=%0d raddr=%0d, required 2 1 0 4", lat, re_n, we_n, ra);
        end
    endtask

    task automatic test_load_lanes();
        int lat, re_n, we_n; logic [AW-1:0] ra;
        logic [3:0] ops [0:5];
        logic [31:0] w;
        sb.push_back('{32'hFFFF_FF88, 1'b0});
        run_req(OP_LB, 32'h13, 32'd0, 1'b0, lat, re_n, we_n, ra);
        sb.push_back('{32'h0000_0088, 1'b0});
        run_req(OP_LBU, 32'h13, 32'd0, 1'b0, lat, re_n, we_n, ra);
        n_vec++;
        if (lat !== 2) begin
            n_bad++;
            $display("FAIL lbu_latency: lat=%0d, required 2", lat);
        end
        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LB};
        w = mem[5];
        for (int i = 0; i < 6; i++) begin
            for (int off = 0; off < 4; off++) begin
                logic [1:0] o2;
                o2 = off[1:0];
                if ((ops[i][1:0] == 2'b01 && o2[0]) || (ops[i][1:0] == 2'b10 && o2 != 2'b00)) continue;
                sb.push_back('{model_load(w, ops[i][2:0], o2), 1'b0});
                run_req(ops[i], 32'h14 + off, 32'd0, 1'b0, lat, re_n, we_n, ra);
            end
        end
    endtask

    task automatic test_wrap();
        int lat, re_n, we_n; logic [AW-1:0] ra;
        sb.push_back('{mem[4], 1'b0});
        run_req(OP_LW, 32'hFFFF_F410, 32'd0, 1'b0, lat, re_n, we_n, ra);
        n_vec++;
        if (ra !== 8'd4) begin
            n_bad++;
            $display("FAIL wrap_addr: raddr=%0d, required 4", ra);
        end
    endtask

    task automatic test_store_sub();
        int lat, re_n, we_n; logic [AW-1:0] ra;
        sb.push_back('{32'd0, 1'b0});
        run_req(OP_SH, 32'h12, 32'h0000_1234, 1'b0, lat, re_n, we_n, ra);
        n_vec++;
        if (lat !== 3 || re_n !== 1 || we_n !== 1 || mem[4] !== 32'h1234_AABB) begin
            n_bad++;
            $display("FAIL sh_merge: lat=%0d re=%0d we=%0d word=%h, required 3 1 1 1234aabb",
                     lat, re_n, we_n, mem[4]);
        end
        sb.push_back('{32'd0, 1'b0});
        run_req(OP_SB, 32'h11, 32'hFFFF_FFCD, 1'b0, lat, re_n, we_n, ra);
        n_vec++;
        if (lat !== 3 || we_n !== 1 || mem[4] !== 32'h1234_CDBB) begin
            n_bad++;
            $display("FAIL sb_merge: lat=%0d we=%0d word=%h, required 3 1 1234cdbb", lat, we_n, mem[4]);
        end
    endtask

    task automatic test_fault();
        int lat, re_n, we_n; logic [AW-1:0] ra;
        logic [3:0]  fops  [0:4];
        logic [31:0] faddr [0:4];
        logic [31:0] keep0;
        fops  = '{OP_LW, OP_LH, 4'b0011, 4'b1100, OP_SW};
        faddr = '{32'h6, 32'h1, 32'h0, 32'h0, 32'h2};
        keep0 = mem[0];
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{32'd0, 1'b1});
            run_req(fops[i], faddr[i], 32'hDEAD_BEEF, 1'b0, lat, re_n, we_n, ra);
            n_vec++;
            if (lat !== 1 || re_n !== 0 || we_n !== 0) begin
                n_bad++;
                $display("FAIL fault_%0d: lat=%0d re=%0d we=%0d, required 1 0 0", i, lat, re_n, we_n);
            end
        end
        n_vec++;
        if (mem[0] !== keep0) begin
            n_bad++;
            $display("FAIL fault_no_write: word0=%h, required %h", mem[0], keep0);
        end
    endtask

    task automatic test_reset_mid();
        int lat, re_n, we_n; logic [AW-1:0] ra;
        logic [31:0] saved;
        saved = mem[8];
        req = 1'b1; op = OP_SB; addr = 32'h21; wdata = 32'h0000_00EE;
        @(negedge clk);
        n_vec++;
        if (ram_re !== 1'b1) begin
            n_bad++;
            $display("FAIL sb_in_rd: re=%b, required 1", ram_re);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({rdata, done, err, stall, ram_ce, ram_we, ram_re, ram_waddr, ram_raddr, ram_wdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: ce=%b re=%b stall=%b, required all zero", ram_ce, ram_re, stall);
        end
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        we_n = 0;
        repeat (2) begin
            @(negedge clk);
            if (ram_we) we_n++;
        end
        n_vec++;
        if (we_n !== 0 || mem[8] !== saved) begin
            n_bad++;
            $display("FAIL reset_no_write: we=%0d word=%h, required 0 %h", we_n, mem[8], saved);
        end
        sb.push_back('{saved, 1'b0});
        run_req(OP_LW, 32'h20, 32'd0, 1'b0, lat, re_n, we_n, ra);
        n_vec++;
        if (lat !== 2) begin
            n_bad++;
            $display("FAIL post_reset_lw: lat=%0d, required 2", lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat, re_n, we_n; logic [AW-1:0] ra;
        sb.push_back('{32'd0, 1'b0});
        run_req(OP_SW, 32'h20, 32'hCAFE_F00D, 1'b1, lat, re_n, we_n, ra);
        n_vec++;
        if (lat !== 2 || re_n !== 0 || we_n !== 1) begin
            n_bad++;
            $display("FAIL sw_timing: lat=%0d re=%0d we=%0d, required 2 0 1", lat, re_n, we_n);
        end
        op = OP_LW;
        @(negedge clk);
        n_vec++;
        if (stall !== 1'b1 || done !== 1'b0 || ram_ce !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: stall=%b done=%b ce=%b, required 1 0 0", stall, done, ram_ce);
        end
        sb.push_back('{32'hCAFE_F00D, 1'b0});
        run_req(OP_LW, 32'h20, 32'd0, 1'b0, lat, re_n, we_n, ra);
        n_vec++;
        if (lat !== 2) begin
            n_bad++;
            $display("FAIL b2b_lw: lat=%0d, required 2", lat);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
        mem[4] = 32'h8899_AABB;
        mem[5] = 32'hF00F_8E71;
        test_reset();
        test_load_word();
        test_load_lanes();
        test_wrap();
        test_store_sub();
        test_fault();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d pending, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
